// File: rtl/led_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer_if
//  Description : Link between led_sequencer and led_controller. Carries the
//                step colour, pulse length, start/kill strobes and the
//                controller's trigger_next return.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_sequencer_if #(
  parameter int DUR_WIDTH = 27
);
  logic [2:0]           rgb;
  logic [DUR_WIDTH-1:0] pulse_duration_cycles;
  logic                 start;
  logic                 kill;
  logic                 trigger_next;

  // Sequencer side
  modport master (
    output rgb,
    output pulse_duration_cycles,
    output start,
    output kill,
    input  trigger_next
  );

  // Controller side
  modport slave (
    input  rgb,
    input  pulse_duration_cycles,
    input  start,
    input  kill,
    output trigger_next
  );
endinterface : led_sequencer_if
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer
//  Description : Plays a programmable table of (rgb, duration) steps into
//                led_controller. Advances on trigger_next, with an optional
//                idle gap between steps, one-shot or looping playback, and
//                abort. Zero-duration entries are skipped without a start.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int DEPTH     = 8,
  parameter int DUR_WIDTH = 27,
  parameter int GAP_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // table write port
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [2:0]                 wr_rgb,
  input  logic [DUR_WIDTH-1:0]       wr_dur,
  // playback configuration and control
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop,
  input  logic [GAP_WIDTH-1:0]       gap_cycles,
  input  logic                       go,
  input  logic                       abort,
  // link to led_controller
  led_sequencer_if.master            ctrl,
  // status
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_DEPTH_L = c_LW'(DEPTH);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_GAP  = 2'd2;
  localparam logic [1:0] c_ST_SKIP = 2'd3;

  // pattern table (not reset; contents are undefined until written)
  logic [2:0]           r_mem_rgb [DEPTH];
  logic [DUR_WIDTH-1:0] r_mem_dur [DEPTH];

  // FSM and latched playback configuration
  logic [1:0]           r_state;
  logic [c_AW-1:0]      r_cur;       // index of the step in flight / pending after a gap
  logic [c_LW-1:0]      r_len;
  logic                 r_loop;
  logic [GAP_WIDTH-1:0] r_gap;
  logic [GAP_WIDTH-1:0] r_gap_cnt;

  // registered outputs
  logic [2:0]           r_rgb;
  logic [DUR_WIDTH-1:0] r_dur;
  logic                 r_start;
  logic                 r_kill;
  logic                 r_busy;
  logic                 r_done;
  logic [c_AW-1:0]      r_step;

  // combinational decode
  logic                 w_adv;
  logic                 w_last;
  logic [c_AW-1:0]      w_next_idx;
  logic [c_AW-1:0]      w_issue_idx;
  logic [2:0]           w_rd_rgb;
  logic [DUR_WIDTH-1:0] w_rd_dur;
  logic [c_LW-1:0]      w_len_clamp;

  logic [1:0]           w_state_nxt;
  logic                 w_issue;
  logic                 w_enter_gap;
  logic                 w_finish;
  logic                 w_go_ok;

  logic [2:0]           w_rgb_d;
  logic [DUR_WIDTH-1:0] w_dur_d;
  logic                 w_start_d;
  logic                 w_kill_d;
  logic                 w_done_d;
  logic [c_AW-1:0]      w_step_d;
  logic [c_AW-1:0]      w_cur_d;
  logic [c_LW-1:0]      w_len_d;
  logic                 w_loop_d;
  logic [GAP_WIDTH-1:0] w_gap_d;
  logic [GAP_WIDTH-1:0] w_gap_cnt_d;

  // A skip behaves like an immediate trigger; in WAIT a trigger landing on
  // the start cycle belongs to the previous pulse and is dropped.
  assign w_adv       = ((r_state == c_ST_WAIT) && ctrl.trigger_next && !r_start) ||
                       (r_state == c_ST_SKIP);
  assign w_last      = ({1'b0, r_cur} == (r_len - c_LW'(1)));
  assign w_next_idx  = w_last ? '0 : (r_cur + c_AW'(1));
  assign w_len_clamp = (num_steps > c_DEPTH_L) ? c_DEPTH_L : num_steps;

  // The entry that would issue this cycle depends only on state, so the
  // table read is resolved before the FSM decision that consumes it.
  assign w_issue_idx = (r_state == c_ST_IDLE) ? '0 :
                       (r_state == c_ST_GAP)  ? r_cur : w_next_idx;
  assign w_rd_rgb    = r_mem_rgb[w_issue_idx];
  assign w_rd_dur    = r_mem_dur[w_issue_idx];

  // Table write port; legal in any state, seen by the next issue of that entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem_rgb[wr_addr] <= wr_rgb;
      r_mem_dur[wr_addr] <= wr_dur;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: decides issue / gap / finish; abort overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_enter_gap = 1'b0;
    w_finish    = 1'b0;
    w_go_ok     = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (go && !abort && (num_steps != '0)) begin
          w_go_ok = 1'b1;
          w_issue = 1'b1;
        end
      end
      c_ST_WAIT, c_ST_SKIP: begin
        if (w_adv) begin
          if (w_last && !r_loop) begin
            w_finish    = 1'b1;
            w_state_nxt = c_ST_IDLE;
          end else if ((r_state == c_ST_WAIT) && (r_gap != '0)) begin
            w_enter_gap = 1'b1;
            w_state_nxt = c_ST_GAP;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      c_ST_GAP: begin
        if (r_gap_cnt == GAP_WIDTH'(1)) begin
          w_issue = 1'b1;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
    if (w_issue) begin
      w_state_nxt = (w_rd_dur != '0) ? c_ST_WAIT : c_ST_SKIP;
    end
    if (abort && (r_state != c_ST_IDLE)) begin
      w_state_nxt = c_ST_IDLE;
      w_issue     = 1'b0;
      w_enter_gap = 1'b0;
      w_finish    = 1'b0;
    end
  end

  // Output logic: next values for the registered outputs and datapath.
  always_comb begin
    w_rgb_d     = r_rgb;
    w_dur_d     = r_dur;
    w_start_d   = 1'b0;
    w_kill_d    = 1'b0;
    w_done_d    = w_finish;
    w_step_d    = r_step;
    w_cur_d     = r_cur;
    w_len_d     = r_len;
    w_loop_d    = r_loop;
    w_gap_d     = r_gap;
    w_gap_cnt_d = r_gap_cnt;

    if (w_go_ok) begin
      w_len_d  = w_len_clamp;
      w_loop_d = loop;
      w_gap_d  = gap_cycles;
    end

    if (w_issue) begin
      w_cur_d = w_issue_idx;
      // zero-duration entries move the cursor but leave outputs untouched
      if (w_rd_dur != '0) begin
        w_start_d = 1'b1;
        w_step_d  = w_issue_idx;
        w_rgb_d   = w_rd_rgb;
        w_dur_d   = w_rd_dur;
      end
    end

    if (w_enter_gap) begin
      w_cur_d     = w_next_idx;
      w_gap_cnt_d = r_gap;
    end else if (r_state == c_ST_GAP) begin
      w_gap_cnt_d = r_gap_cnt - GAP_WIDTH'(1);
    end

    // kill is pulsed even from IDLE; drive is cleared only when stopping a run
    if (abort) begin
      w_kill_d = 1'b1;
      if (r_state != c_ST_IDLE) begin
        w_rgb_d = '0;
        w_dur_d = '0;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb     <= '0;
      r_dur     <= '0;
      r_start   <= 1'b0;
      r_kill    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_step    <= '0;
      r_cur     <= '0;
      r_len     <= '0;
      r_loop    <= 1'b0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_rgb     <= w_rgb_d;
      r_dur     <= w_dur_d;
      r_start   <= w_start_d;
      r_kill    <= w_kill_d;
      r_busy    <= (w_state_nxt != c_ST_IDLE);
      r_done    <= w_done_d;
      r_step    <= w_step_d;
      r_cur     <= w_cur_d;
      r_len     <= w_len_d;
      r_loop    <= w_loop_d;
      r_gap     <= w_gap_d;
      r_gap_cnt <= w_gap_cnt_d;
    end
  end

  assign ctrl.rgb                   = r_rgb;
  assign ctrl.pulse_duration_cycles = r_dur;
  assign ctrl.start                 = r_start;
  assign ctrl.kill                  = r_kill;
  assign busy                       = r_busy;
  assign done                       = r_done;
  assign step_idx                   = r_step;

endmodule : led_sequencer
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_sequencer
//  Description : Self-checking bench for led_sequencer: cycle vector table for
//                one-shot playback, plus directed gap, loop/abort, skip/clamp,
//                mid-run write and async reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [2:0]  wr_rgb;
  logic [26:0] wr_dur;
  logic [3:0]  num_steps;
  logic        loop;
  logic [15:0] gap_cycles;
  logic        go;
  logic        abort;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  int total = 0;
  int bad   = 0;

  led_sequencer_if #(.DUR_WIDTH(27)) u_if ();

  led_sequencer #(.DEPTH(8), .DUR_WIDTH(27), .GAP_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_rgb     (wr_rgb),
    .wr_dur     (wr_dur),
    .num_steps  (num_steps),
    .loop       (loop),
    .gap_cycles (gap_cycles),
    .go         (go),
    .abort      (abort),
    .ctrl       (u_if.master),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        go;
    logic        trig;
    logic [3:0]  nsteps;
    logic        e_start;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_rgb;
    logic [26:0] e_dur;
    logic [2:0]  e_step;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] c, input logic [26:0] d);
    wr_en = 1'b1; wr_addr = a; wr_rgb = c; wr_dur = d;
    step();
    wr_en = 1'b0;
  endtask

  // one idle cycle, one trigger edge, then expect the next start after 'gap' more edges
  task automatic trig_expect(input int gap, input logic [2:0] prgb, input logic [26:0] pdur,
                             input logic [2:0] nrgb, input logic [26:0] ndur, input logic [2:0] nstep);
    step();
    u_if.trigger_next = 1'b1;
    step();
    u_if.trigger_next = 1'b0;
    for (int k = 0; k < gap; k++) begin
      chk("gap_start_low", u_if.start, 0);
      chk("gap_rgb_held", u_if.rgb, prgb);
      chk("gap_dur_held", u_if.pulse_duration_cycles, pdur);
      step();
    end
    chk("next_start", u_if.start, 1);
    chk("next_rgb", u_if.rgb, nrgb);
    chk("next_dur", u_if.pulse_duration_cycles, ndur);
    chk("next_step_idx", step_idx, nstep);
  endtask

  initial begin
    int          n_start;
    int          n_done;
    logic        prev;
    logic        fin;
    logic [2:0]  got [8];
    logic [2:0]  exp_idx [7];

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_rgb = '0; wr_dur = '0;
    num_steps = '0; loop = 1'b0; gap_cycles = '0; go = 1'b0; abort = 1'b0;
    u_if.trigger_next = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_rgb", u_if.rgb, 0);
    chk("rst_dur", u_if.pulse_duration_cycles, 0);
    chk("rst_start", u_if.start, 0);
    chk("rst_kill", u_if.kill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    wr(3'd0, 3'b101, 27'd10);
    wr(3'd1, 3'b010, 27'd5);
    wr(3'd2, 3'b111, 27'd3);

    // ---------------- one-shot vector table ----------------
    //           go trig ns  start busy done rgb     dur     step
    vecs[0] = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 3'b101, 27'd10, 3'd0};
    vecs[1] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 3'b101, 27'd10, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 3'b010, 27'd5,  3'd1};
    vecs[3] = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 3'b010, 27'd5,  3'd1};
    vecs[4] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 3'b010, 27'd5,  3'd1};
    vecs[5] = '{1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 3'b111, 27'd3,  3'd2};
    vecs[6] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 3'b111, 27'd3,  3'd2};
    vecs[7] = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 3'b111, 27'd3,  3'd2};
    vecs[8] = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3'b111, 27'd3,  3'd2};
    vecs[9] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b111, 27'd3,  3'd2};
    for (int i = 0; i < 10; i++) begin
      go = vecs[i].go;
      u_if.trigger_next = vecs[i].trig;
      num_steps = vecs[i].nsteps;
      step();
      chk($sformatf("v%0d_start", i), u_if.start, vecs[i].e_start);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_kill", i), u_if.kill, 0);
      chk($sformatf("v%0d_rgb", i), u_if.rgb, vecs[i].e_rgb);
      chk($sformatf("v%0d_dur", i), u_if.pulse_duration_cycles, vecs[i].e_dur);
      chk($sformatf("v%0d_step", i), step_idx, vecs[i].e_step);
    end
    go = 1'b0; u_if.trigger_next = 1'b0;

    // ---------------- gap = 4 ----------------
    num_steps = 4'd3; loop = 1'b0; gap_cycles = 16'd4; go = 1'b1;
    step();
    go = 1'b0;
    chk("gap_first_start", u_if.start, 1);
    chk("gap_first_rgb", u_if.rgb, 3'b101);
    trig_expect(4, 3'b101, 27'd10, 3'b010, 27'd5, 3'd1);
    trig_expect(4, 3'b010, 27'd5, 3'b111, 27'd3, 3'd2);
    step();
    u_if.trigger_next = 1'b1;
    step();
    u_if.trigger_next = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_busy_fall", busy, 0);

    // ---------------- loop + go-while-busy + abort ----------------
    num_steps = 4'd2; loop = 1'b1; gap_cycles = 16'd0; go = 1'b1;
    step();
    go = 1'b0;
    chk("loop_s0_start", u_if.start, 1);
    chk("loop_s0_idx", step_idx, 0);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    chk("go_busy_no_start", u_if.start, 0);
    chk("go_busy_still_busy", busy, 1);
    trig_expect(0, 3'b101, 27'd10, 3'b010, 27'd5, 3'd1);
    trig_expect(0, 3'b010, 27'd5, 3'b101, 27'd10, 3'd0);
    trig_expect(0, 3'b101, 27'd10, 3'b010, 27'd5, 3'd1);
    trig_expect(0, 3'b010, 27'd5, 3'b101, 27'd10, 3'd0);
    step();
    abort = 1'b1; u_if.trigger_next = 1'b1;
    step();
    abort = 1'b0; u_if.trigger_next = 1'b0;
    chk("abort_kill", u_if.kill, 1);
    chk("abort_rgb", u_if.rgb, 0);
    chk("abort_dur", u_if.pulse_duration_cycles, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_start", u_if.start, 0);
    for (int k = 0; k < 3; k++) begin
      u_if.trigger_next = (k != 1);
      step();
      chk("post_abort_start", u_if.start, 0);
      chk("post_abort_done", done, 0);
      chk("post_abort_kill", u_if.kill, 0);
    end
    u_if.trigger_next = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_kill", u_if.kill, 1);
    chk("idle_abort_busy", busy, 0);
    step();
    chk("idle_abort_kill_pulse", u_if.kill, 0);

    // ---------------- skip + clamp ----------------
    wr(3'd0, 3'd1, 27'd2);
    wr(3'd1, 3'd2, 27'd0);
    for (int k = 2; k < 8; k++) wr(3'(k), 3'(k), 27'(k + 1));
    exp_idx = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 8; k++) got[k] = 3'd1;
    n_start = 0; n_done = 0; prev = 1'b0; fin = 1'b0;
    num_steps = 4'd15; loop = 1'b0; gap_cycles = 16'd0; go = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      step();
      go = 1'b0;
      if (u_if.start) begin
        if (n_start < 8) got[n_start] = step_idx;
        n_start++;
      end
      if (done) begin
        n_done++;
        fin = 1'b1;
      end
      u_if.trigger_next = prev;
      prev = u_if.start;
    end
    u_if.trigger_next = 1'b0;
    chk("skip_finished_in_budget", fin, 1);
    chk("skip_start_count", n_start, 7);
    chk("skip_done_count", n_done, 1);
    for (int k = 0; k < 7; k++) chk($sformatf("skip_idx%0d", k), got[k], exp_idx[k]);
    step();
    chk("skip_busy_after_done", busy, 0);
    num_steps = 4'd0; go = 1'b1;
    step();
    go = 1'b0;
    chk("zero_steps_busy", busy, 0);
    chk("zero_steps_start", u_if.start, 0);
    step();
    chk("zero_steps_done", done, 0);

    // ---------------- mid-run write + async reset ----------------
    wr(3'd0, 3'b101, 27'd10);
    wr(3'd1, 3'b010, 27'd5);
    num_steps = 4'd2; loop = 1'b1; go = 1'b1;
    step();
    go = 1'b0;
    chk("mw_start", u_if.start, 1);
    wr(3'd0, 3'b110, 27'd11);
    chk("mw_rgb_held", u_if.rgb, 3'b101);
    chk("mw_dur_held", u_if.pulse_duration_cycles, 10);
    trig_expect(0, 3'b101, 27'd10, 3'b010, 27'd5, 3'd1);
    trig_expect(0, 3'b010, 27'd5, 3'b110, 27'd11, 3'd0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_rgb", u_if.rgb, 0);
    chk("ar_dur", u_if.pulse_duration_cycles, 0);
    chk("ar_busy", busy, 0);
    chk("ar_start", u_if.start, 0);
    chk("ar_step", step_idx, 0);
    chk("ar_kill", u_if.kill, 0);
    chk("ar_done", done, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_led_sequencer
`default_nettype wire
